// File: rtl/dds_pkg.sv
// Shared constants and elaboration-time helpers for the DDS sine source.
//   - quadrant encodings of the two MSBs of the truncated phase
//   - AMP_UNITY: amplitude word meaning unity gain (also the clamp ceiling)
//   - mid_scale(): offset-binary zero level for a given output width
//   - sine_q(): quarter-wave ROM contents, evaluated as constants only
package dds_pkg;

    localparam logic [1:0] QUAD_0 = 2'd0;
    localparam logic [1:0] QUAD_1 = 2'd1;
    localparam logic [1:0] QUAD_2 = 2'd2;
    localparam logic [1:0] QUAD_3 = 2'd3;

    localparam int unsigned AMP_UNITY = 256;
    localparam int unsigned AMP_SHIFT = 8;

    localparam real PI = 3.14159265358979323846;

    function automatic int unsigned mid_scale(input int unsigned out_w);
        return 32'd1 << (out_w - 1);
    endfunction

    // Half-LSB phase offset makes entry a and its mirror ~a describe the same
    // magnitude, so quadrant folding needs no duplicated entries.
    function automatic int unsigned sine_q(input int unsigned a, input int unsigned addr_w,
                                           input int unsigned out_w);
        real peak;
        real x;
        peak = real'((32'd1 << (out_w - 1)) - 1);
        x    = (PI / 2.0) * (real'(a) + 0.5) / real'(32'd1 << addr_w);
        return $unsigned($rtoi(peak * $sin(x) + 0.5));
    endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Synchronous-read quarter-wave sine ROM, 2^ADDR_W entries of OUT_W-1 bits.
// Ports:
//   clk   - clock
//   rst_n - synchronous active-low reset, clears the read register
//   addr  - folded quarter-wave address
//   data  - registered magnitude, valid one edge after addr
module sine_quarter_rom
    import dds_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned OUT_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    output logic [OUT_W-2:0]  data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [OUT_W-2:0] table_w [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam int unsigned VAL = sine_q(i, ADDR_W, OUT_W);
        assign table_w[i] = VAL[OUT_W-2:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data <= '0;
        end else begin
            data <= table_w[addr];
        end
    end

endmodule

// File: rtl/dds_sine_gen.sv
// DDS sine source: phase accumulator, phase offset, quarter-wave LUT with
// quadrant folding, amplitude scaling, 4-stage registered datapath.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   en           - advance accumulator; marks the resulting sample valid
//   freq_word    - tuning word, captured into shadow on update
//   phase_offset - offset in truncated-phase units, captured on update
//   update       - one-cycle shadow load strobe
//   sync_clr     - clear accumulator to 0
//   amp          - amplitude (256 = unity, larger values clamp)
//   data_out     - offset-binary sample, held while data_valid=0
//   data_valid   - data_out came from an en=1 accumulator cycle
//   wrap         - one-cycle pulse on accumulator carry-out
module dds_sine_gen
    import dds_pkg::*;
#(
    parameter int unsigned PHASE_W    = 24,
    parameter int unsigned LUT_ADDR_W = 8,
    parameter int unsigned OUT_W      = 10,
    parameter int unsigned AMP_W      = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [PHASE_W-1:0]    freq_word,
    input  logic [LUT_ADDR_W+1:0] phase_offset,
    input  logic                  update,
    input  logic                  sync_clr,
    input  logic [AMP_W-1:0]      amp,
    output logic [OUT_W-1:0]      data_out,
    output logic                  data_valid,
    output logic                  wrap
);

    localparam int unsigned      P_W     = LUT_ADDR_W + 2;
    localparam int unsigned      PROD_W  = OUT_W + AMP_W + 1;
    localparam int unsigned      MID_I   = mid_scale(OUT_W);
    localparam logic [OUT_W-1:0] MID     = MID_I[OUT_W-1:0];
    localparam logic [AMP_W-1:0] AMP_MAX = AMP_W'(AMP_UNITY);

    // Accumulator and shadow registers
    logic [PHASE_W-1:0] acc_q, fw_sh_q;
    logic [P_W-1:0]     ofs_sh_q;
    logic               vld0_q;
    logic [PHASE_W:0]   acc_sum;

    assign acc_sum = {1'b0, acc_q} + {1'b0, fw_sh_q};

    // The accumulator uses the old shadow word at the edge that loads a new one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= '0;
            fw_sh_q  <= '0;
            ofs_sh_q <= '0;
            vld0_q   <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            if (update) begin
                fw_sh_q  <= freq_word;
                ofs_sh_q <= phase_offset;
            end
            vld0_q <= en;
            if (sync_clr) begin
                acc_q <= '0;
                wrap  <= 1'b0;
            end else if (en) begin
                acc_q <= acc_sum[PHASE_W-1:0];
                wrap  <= acc_sum[PHASE_W];
            end else begin
                wrap  <= 1'b0;
            end
        end
    end

    // Stage 1: truncate, offset, fold into first quadrant
    logic [P_W-1:0]        phase_t;
    logic [1:0]            quad;
    logic [LUT_ADDR_W-1:0] idx, addr_d, addr_q;
    logic                  neg1_q, vld1_q;

    assign phase_t = acc_q[PHASE_W-1 -: P_W] + ofs_sh_q;
    assign quad    = phase_t[P_W-1 -: 2];
    assign idx     = phase_t[LUT_ADDR_W-1:0];

    always_comb begin
        addr_d = idx;
        if (quad == QUAD_1 || quad == QUAD_3) begin
            addr_d = ~idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= '0;
            neg1_q <= 1'b0;
            vld1_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            neg1_q <= quad[1];
            vld1_q <= vld0_q;
        end
    end

    // Stage 2: ROM read
    logic [OUT_W-2:0] rom_data;
    logic             neg2_q, vld2_q;

    sine_quarter_rom #(
        .ADDR_W (LUT_ADDR_W),
        .OUT_W  (OUT_W)
    ) u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr_q),
        .data  (rom_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            neg2_q <= 1'b0;
            vld2_q <= 1'b0;
        end else begin
            neg2_q <= neg1_q;
            vld2_q <= vld1_q;
        end
    end

    // Stage 3: sign restore and amplitude scaling (arithmetic shift floors)
    logic signed [OUT_W-1:0]  mag, smp;
    logic [AMP_W-1:0]         amp_c;
    logic signed [PROD_W-1:0] prod_full, prod_sh;
    logic [OUT_W-1:0]         prod_q;
    logic                     vld3_q;
    logic                     unused_prod;

    assign mag         = $signed({1'b0, rom_data});
    assign smp         = neg2_q ? -mag : mag;
    assign amp_c       = (amp > AMP_MAX) ? AMP_MAX : amp;
    assign prod_full   = PROD_W'(smp) * PROD_W'($signed({1'b0, amp_c}));
    assign prod_sh     = prod_full >>> AMP_SHIFT;
    assign unused_prod = ^prod_sh[PROD_W-1:OUT_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_q <= '0;
            vld3_q <= 1'b0;
        end else begin
            prod_q <= prod_sh[OUT_W-1:0];
            vld3_q <= vld2_q;
        end
    end

    // Stage 4: offset-binary output, held across bubbles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out   <= MID;
            data_valid <= 1'b0;
        end else begin
            data_valid <= vld3_q;
            if (vld3_q) begin
                data_out <= prod_q + MID;
            end
        end
    end

endmodule

// File: doc/dds_sine_gen.md
Name: dds_sine_gen

Overview:
Parametrised direct digital synthesis (DDS) sine source. It contains:
- a phase accumulator with a runtime frequency tuning word;
- a phase offset input;
- a quarter-wave sine LUT with quadrant folding;
- amplitude scaling;
- a registered 4-stage datapath.
It produces an offset-binary sample stream for the DAC/PWM output path and replaces fixed-range, full-wave combinational phase-to-amplitude decoding.

Parameters:
PHASE_W, 24, phase accumulator width (bits)
LUT_ADDR_W, 8, quarter-wave LUT address width (2^LUT_ADDR_W entries); truncated phase width P_W = LUT_ADDR_W+2
OUT_W, 10, output sample width, offset-binary, mid-scale 2^(OUT_W-1)
AMP_W, 9, amplitude word width; 256 = unity gain

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
en  in  1  accumulator advance enable; marks the sample valid
freq_word  in  PHASE_W  tuning word; latched on update
phase_offset  in  LUT_ADDR_W+2  phase offset in truncated-phase units; latched on update
update  in  1  one-cycle strobe; copies freq_word/phase_offset into shadow registers
sync_clr  in  1  clears the accumulator to 0 (channel phase alignment)
amp  in  AMP_W  amplitude scale, sampled in stage 3; values >256 clamp to 256
data_out  out  OUT_W  sine sample, offset-binary
data_valid  out  1  data_out holds a sample from an en=1 accumulator cycle
wrap  out  1  one-cycle pulse on accumulator carry-out

Behaviour:
- Reset (rst_n=0 at an edge) forces:
  - acc=0, fw_sh=0, ofs_sh=0, all stage registers 0, valid pipe 0;
  - data_out=2^(OUT_W-1) (512 at defaults), data_valid=0, wrap=0.
  - Reset asserted mid-stream takes effect at that edge; in-flight samples are discarded.
- Shadow registers: update=1 loads fw_sh/ofs_sh at the edge. The new word first drives the accumulator increment at the following edge, which gives glitch-free retune.
- Accumulator:
  - if sync_clr: acc<=0, wrap<=0;
  - else if en: {carry,acc}<=acc+fw_sh, wrap<=carry;
  - else: hold, wrap<=0.
  - sync_clr and update together: both apply; the accumulator restarts from 0 using the new word.
  - Wrap-around is modulo 2^PHASE_W with no saturation.
- Stage 1 (registered):
  - p = acc[PHASE_W-1 -: P_W] + ofs_sh, mod 2^P_W;
  - q = p[P_W-1:P_W-2], idx = p[LUT_ADDR_W-1:0];
  - addr = idx for q∈{0,2}; addr = ~idx for q∈{1,3};
  - neg = q[1].
- Stage 2: registered ROM read, lut[a] = round((2^(OUT_W-1)-1)·sin(π/2·(a+0.5)/2^LUT_ADDR_W)), unsigned OUT_W-1 bits.
  - The half-LSB offset makes the mirror exact; no duplicate entries are stored.
- Stage 3: s = neg ? -lut : lut, signed OUT_W bits. prod = s·min(amp,256), then shifted arithmetically right by 8 (floor toward −inf).
- Stage 4: data_out <= prod + 2^(OUT_W-1). The result range is [1, 2^OUT_W-1] and never overflows.
- Latency:
  - the accumulator value present in cycle k appears on data_out after 4 edges;
  - data_valid is en of the cycle that accumulator value was produced, delayed identically;
  - when data_valid=0, data_out holds its last value.
- en=0 stalls only the accumulator. The pipeline keeps draining; bubbles carry valid=0.

Decomposition:
- Package dds_pkg holds:
  - constants: quadrant encodings, AMP_UNITY=256;
  - function mid_scale(OUT_W);
  - ROM init function sine_q(a, LUT_ADDR_W, OUT_W).
- One sub-module: sine_quarter_rom (synchronous-read ROM, 2^LUT_ADDR_W × (OUT_W-1)), initialised from the package function.

Test Plan:
1. Reset check: rst_n=0 for 3 cycles, then release with en=0 → data_out=512, data_valid=0, wrap=0; all stay unchanged while en=0.
2. Quadrant check: update with fw=2^22 (quarter turn), ofs=0, amp=256, en=1 → valid samples in order 514, 1023, 510, 1; wrap pulses once every 4 accumulator steps.
3. Amplitude and offset:
   - amp=128, fw=2^22 → samples 513, 767, 511, 256;
   - amp=300 → identical to amp=256;
   - ofs=256 with fw=0 → constant 1023.
4. Retune/sync: update (fw=2^21) and sync_clr together mid-stream → the accumulator returns to 0. Afterwards, truncated-phase samples are 0, 128, 256… with no intermediate-word sample.
5. Stall and reset:
   - en toggling 1,0,1 → data_valid follows 4 edges later; the accumulator holds during en=0;
   - rst_n=0 for 1 cycle mid-stream → data_out=512 and data_valid=0 at the next edge.
6. Sweep: fw=1, 2^PHASE_W cycles (scaled PHASE_W=12 build) → data_out is monotonic within each quadrant, symmetric across quadrants, and matches the golden model to ±0 LSB.
